// File: rtl/uart_pkg.sv
// Shared UART definitions: baud table, parity select,
// done thresholds and the receive state encoding.
package uart_pkg;

  localparam logic [15:0] BAUD_1200   = 16'd0;
  localparam logic [15:0] BAUD_2400   = 16'd1;
  localparam logic [15:0] BAUD_4800   = 16'd2;
  localparam logic [15:0] BAUD_9600   = 16'd3;
  localparam logic [15:0] BAUD_19200  = 16'd4;
  localparam logic [15:0] BAUD_38400  = 16'd5;
  localparam logic [15:0] BAUD_57600  = 16'd6;
  localparam logic [15:0] BAUD_115200 = 16'd7;

  localparam int PARITY_BIT = 0;

  localparam logic [5:0] DONE_T [0:5] = '{
    6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32
  };

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Any index past the table falls back to the fastest rate.
  function automatic logic [31:0] baud_limit(
    input int unsigned freq,
    input logic [15:0] idx
  );
    case (idx)
      BAUD_1200:  return freq / 1200 - 1;
      BAUD_2400:  return freq / 2400 - 1;
      BAUD_4800:  return freq / 4800 - 1;
      BAUD_9600:  return freq / 9600 - 1;
      BAUD_19200: return freq / 19200 - 1;
      BAUD_38400: return freq / 38400 - 1;
      BAUD_57600: return freq / 57600 - 1;
      default:    return freq / 115200 - 1;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input,
// with a selectable reset level.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, parity, one stop bit,
// one-entry valid/ready output and byte-count status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FREQ         = 50000000,
  parameter int CONFIG_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx,
  output logic [7:0]                dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      overrun,
  input  logic [CONFIG_WIDTH/2-1:0] enable,
  output logic                      done,
  input  logic [CONFIG_WIDTH/2-1:0] clear,
  input  logic [CONFIG_WIDTH-1:0]   rx_conf
);

  rx_state_e   state_q, state_d;
  logic [31:0] baud_cnt_q, baud_cnt_d;
  logic [31:0] lim_q, lim_d;
  logic [31:0] half;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        pmis_q, pmis_d;
  logic        brk_q, brk_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;
  logic        fe_q, fe_d;
  logic        ovr_q, ovr_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic        rx_s, deliver, load;
  logic        enable_done, clear_done, done_w;
  logic [15:0] baud_idx;
  logic        odd;
  logic        unused;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign baud_idx = rx_conf[CONFIG_WIDTH-1 -: 16];
  assign odd      = rx_conf[PARITY_BIT];
  assign half     = lim_q >> 1;
  assign unused   = ^{enable[CONFIG_WIDTH/2-1:6],
                      clear[CONFIG_WIDTH/2-1:6],
                      rx_conf[CONFIG_WIDTH/2-1:1]};

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 32'd1;
    lim_d      = lim_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    pmis_d     = pmis_q;
    brk_d      = brk_q;
    deliver    = 1'b0;
    fe_d       = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        baud_cnt_d = '0;
        brk_d      = 1'b0;
        if (!rx_s) begin
          state_d = RX_START;
          lim_d   = baud_limit(FREQ, baud_idx);
        end
      end
      RX_START: begin
        if (baud_cnt_q == half) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == lim_q) begin
          baud_cnt_d = '0;
          shreg_d    = {rx_s, shreg_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (baud_cnt_q == lim_q) begin
          baud_cnt_d = '0;
          pmis_d     = rx_s ^ (odd ? ~^shreg_q : ^shreg_q);
          state_d    = RX_STOP;
        end
      end
      RX_STOP: begin
        // After a bad stop bit, wait out the break before re-arming.
        if (brk_q) begin
          if (rx_s) state_d = RX_IDLE;
        end else if (baud_cnt_q == lim_q) begin
          baud_cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = RX_IDLE;
          end else begin
            fe_d  = 1'b1;
            brk_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ovr_d   = deliver & valid_q & ~dout_ready;
    load    = deliver & ~ovr_d;
    dout_d  = dout_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    if (load) begin
      dout_d  = shreg_q;
      valid_d = 1'b1;
      perr_d  = pmis_q;
    end else if (valid_q & dout_ready) begin
      valid_d = 1'b0;
    end
  end

  assign enable_done = |enable[5:0];
  assign clear_done  = |clear[5:0];

  always_comb begin
    done_w = 1'b0;
    for (int i = 0; i < 6; i++)
      done_w = done_w | (enable[i] & (byte_cnt_q == DONE_T[i]));
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (enable_done & clear_done)
      byte_cnt_d = '0;
    else if (load & enable_done & ~done_w)
      byte_cnt_d = byte_cnt_q + 6'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      baud_cnt_q <= '0;
      lim_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      pmis_q     <= 1'b0;
      brk_q      <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      lim_q      <= lim_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      pmis_q     <= pmis_d;
      brk_q      <= brk_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;
  assign done       = done_w;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a 10 MHz clock:
// 115200 -> 86 cycles/bit (L=85,H=42), 9600 -> 1041 (L=1040).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int P_FAST = 86;
  localparam int P_SLOW = 1041;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;
  logic [15:0] enable = '0;
  logic        done;
  logic [15:0] clear = '0;
  logic [31:0] rx_conf = {16'd7, 16'd0};

  int vectors = 0;
  int miscompares = 0;
  int fe_cyc = 0;
  int ovr_cyc = 0;
  int base;

  uart_rx #(.FREQ(10000000), .CONFIG_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .enable     (enable),
    .done       (done),
    .clear      (clear),
    .rx_conf    (rx_conf)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (frame_err) fe_cyc <= fe_cyc + 1;
    if (overrun)   ovr_cyc <= ovr_cyc + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic p,
                            input logic stop,
                            input int per);
    logic [10:0] f;
    f = {stop, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (per) @(posedge clock);
    end
  endtask

  task automatic accept();
    @(negedge clock);
    dout_ready = 1'b1;
    @(negedge clock);
    dout_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", dut.state_q, RX_IDLE);

    // 0xA5 even parity at 115200
    send_frame(8'hA5, 1'b0, 1'b1, P_FAST);
    @(negedge clock);
    check("a5_dout", dout, 8'hA5);
    check("a5_valid", dout_valid, 1'b1);
    check("a5_perr", parity_err, 1'b0);
    dout_ready = 1'b1;
    @(negedge clock);
    check("a5_drop", dout_valid, 1'b0);
    dout_ready = 1'b0;

    // odd parity at 9600: 0x03 needs p=1
    rx_conf = {16'd3, 16'd1};
    send_frame(8'h03, 1'b1, 1'b1, P_SLOW);
    @(negedge clock);
    check("odd_ok_dout", dout, 8'h03);
    check("odd_ok_perr", parity_err, 1'b0);
    accept();
    send_frame(8'h03, 1'b0, 1'b1, P_SLOW);
    @(negedge clock);
    check("odd_bad_valid", dout_valid, 1'b1);
    check("odd_bad_perr", parity_err, 1'b1);
    accept();
    rx_conf = {16'd7, 16'd0};

    // short low pulse must be rejected
    rx = 1'b0;
    repeat (30) @(posedge clock);
    rx = 1'b1;
    repeat (100) @(posedge clock);
    @(negedge clock);
    check("glitch_valid", dout_valid, 1'b0);
    check("glitch_state", dut.state_q, RX_IDLE);

    // stop bit 0, then a held break
    base = fe_cyc;
    send_frame(8'h5A, 1'b0, 1'b0, P_FAST);
    repeat (200) @(posedge clock);
    @(negedge clock);
    check("brk_ferr_cnt", fe_cyc - base, 1);
    check("brk_valid", dout_valid, 1'b0);
    check("brk_state", dut.state_q, RX_STOP);
    rx = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("brk_exit", dut.state_q, RX_IDLE);

    // overrun: second byte dropped
    base = ovr_cyc;
    send_frame(8'h11, 1'b0, 1'b1, P_FAST);
    send_frame(8'h22, 1'b0, 1'b1, P_FAST);
    @(negedge clock);
    check("ovr_dout", dout, 8'h11);
    check("ovr_valid", dout_valid, 1'b1);
    check("ovr_cnt", ovr_cyc - base, 1);
    dout_ready = 1'b1;
    @(negedge clock);
    check("ovr_clear", dout_valid, 1'b0);

    // byte count to threshold 4, then saturate
    enable = 16'h0004;
    for (int i = 0; i < 3; i++)
      send_frame(8'h10 + 8'(i), ^(8'h10 + 8'(i)), 1'b1, P_FAST);
    @(negedge clock);
    check("st_cnt3", dut.byte_cnt_q, 6'd3);
    check("st_done3", done, 1'b0);
    send_frame(8'h13, ^8'h13, 1'b1, P_FAST);
    @(negedge clock);
    check("st_cnt4", dut.byte_cnt_q, 6'd4);
    check("st_done4", done, 1'b1);
    send_frame(8'h14, ^8'h14, 1'b1, P_FAST);
    @(negedge clock);
    check("st_cnt5", dut.byte_cnt_q, 6'd4);
    check("st_done5", done, 1'b1);
    clear = 16'h0001;
    @(negedge clock);
    clear = 16'h0000;
    check("st_clr_cnt", dut.byte_cnt_q, 6'd0);
    check("st_clr_done", done, 1'b0);
    enable = 16'h0000;
    dout_ready = 1'b0;

    // rate change mid-frame must not disturb it
    fork
      send_frame(8'h3C, 1'b0, 1'b1, P_FAST);
      begin
        repeat (300) @(posedge clock);
        rx_conf = {16'd3, 16'd0};
      end
    join
    @(negedge clock);
    check("cfg_dout", dout, 8'h3C);
    check("cfg_valid", dout_valid, 1'b1);
    accept();
    rx_conf = {16'd7, 16'd0};

    // reset in the middle of the data bits
    rx = 1'b0;
    repeat (P_FAST) @(posedge clock);
    rx = 1'b1;
    repeat (P_FAST) @(posedge clock);
    rx = 1'b0;
    repeat (P_FAST / 2) @(posedge clock);
    @(negedge clock);
    check("mid_state", dut.state_q, RX_DATA);
    rx = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    reset = 1'b0;
    repeat (300) @(posedge clock);
    @(negedge clock);
    check("rr_state", dut.state_q, RX_IDLE);
    check("rr_valid", dout_valid, 1'b0);
    check("rr_dout", dout, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
